// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types for the binary/Gray counter and its decoder.
package gray_pkg;

  // Widest code the helpers handle; callers zero-extend narrower values.
  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic {
    DN = 1'b0,
    UP = 1'b1
  } dir_e;

  // Binary to reflected Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running from the MSB downward.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits; 7 bits cover 0..32.
  function automatic logic [6:0] popcount(input gray_word_t v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Combinational check that two successive Gray codes differ in exactly one bit.
module gray_step_chk
  import gray_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_old_gray,
  input  logic [W-1:0] i_new_gray,
  output logic         o_one_bit_change
);

  logic [GRAY_MAX_W-1:0] w_diff;

  assign w_diff           = GRAY_MAX_W'(i_old_gray ^ i_new_gray);
  assign o_one_bit_change = (popcount(w_diff) == 7'd1);

endmodule

// File: rtl/bin_gray_cnt.sv
// Registered binary up/down counter with a zero-latency Gray-coded copy,
// presented over a valid/ready interface, with wrap pulse and sticky step error.
module bin_gray_cnt
  import gray_pkg::*;
#(
  parameter int unsigned W    = 4,
  parameter int unsigned INIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] bin_q,
  output logic [W-1:0] gray_q,
  output logic         tc,
  output logic         err
);

  localparam logic [W-1:0] MAX_VAL   = {W{1'b1}};
  localparam logic [W-1:0] ZERO_VAL  = {W{1'b0}};
  localparam logic [W-1:0] ONE_VAL   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] INIT_BIN  = W'(INIT);
  localparam logic [W-1:0] INIT_GRAY = W'(bin2gray(GRAY_MAX_W'(INIT_BIN)));

  logic         r_valid;
  logic [W-1:0] r_bin;
  logic [W-1:0] r_gray;
  logic         r_tc;
  logic         r_err;

  logic         w_xfer;
  logic         w_step;
  dir_e         w_dir;
  logic [W-1:0] w_bin_nxt;
  logic [W-1:0] w_gray_nxt;
  logic         w_wrap;
  logic         w_one_bit;
  logic         w_err_set;

  assign w_xfer = r_valid & out_ready;
  assign w_step = w_xfer & en & ~load;
  assign w_dir  = dir_e'(up_dn);

  // Next binary value: load wins, otherwise step in the sampled direction, else hold.
  always_comb begin
    w_bin_nxt = r_bin;
    w_wrap    = 1'b0;
    if (load) begin
      w_bin_nxt = load_val;
    end else if (w_step) begin
      case (w_dir)
        UP: begin
          w_bin_nxt = r_bin + ONE_VAL;
          w_wrap    = (r_bin == MAX_VAL);
        end
        DN: begin
          w_bin_nxt = r_bin - ONE_VAL;
          w_wrap    = (r_bin == ZERO_VAL);
        end
        default: begin
          w_bin_nxt = r_bin;
          w_wrap    = 1'b0;
        end
      endcase
    end else begin
      w_bin_nxt = r_bin;
    end
  end

  // Gray code is derived from the next-state binary so both registers update together.
  assign w_gray_nxt = W'(bin2gray(GRAY_MAX_W'(w_bin_nxt)));

  gray_step_chk #(.W(W)) u_step_chk (
    .i_old_gray       (r_gray),
    .i_new_gray       (w_gray_nxt),
    .o_one_bit_change (w_one_bit)
  );

  // Only real steps are judged; loads may jump arbitrarily.
  assign w_err_set = w_step & ~w_one_bit;

  // Counter, handshake and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_bin   <= INIT_BIN;
      r_gray  <= INIT_GRAY;
      r_tc    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b1;
      r_bin   <= w_bin_nxt;
      r_gray  <= w_gray_nxt;
      r_tc    <= w_wrap;
      r_err   <= r_err | w_err_set;
    end
  end

  assign out_valid = r_valid;
  assign bin_q     = r_bin;
  assign gray_q    = r_gray;
  assign tc        = r_tc;
  assign err       = r_err;

endmodule

// File: tb/tb_bin_gray_cnt.sv
// Self-checking bench for bin_gray_cnt: directed scenarios plus randomized
// traffic compared against an arithmetic reference model (W=4 and W=3).
module tb_bin_gray_cnt;

  logic       clk;
  // W=4 instance
  logic       rst_n, en, up_dn, load, out_ready;
  logic [3:0] load_val;
  logic       out_valid, tc, err;
  logic [3:0] bin_q, gray_q;
  // W=3 instance
  logic       rst3_n, en3, up_dn3, load3, out_ready3;
  logic [2:0] load_val3;
  logic       out_valid3, tc3, err3;
  logic [2:0] bin_q3, gray_q3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m4_bin, m4_valid, m4_tc;
  int m3_bin, m3_valid, m3_tc;

  bin_gray_cnt #(.W(4), .INIT(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .out_ready(out_ready), .out_valid(out_valid),
    .bin_q(bin_q), .gray_q(gray_q), .tc(tc), .err(err)
  );

  bin_gray_cnt #(.W(3), .INIT(0)) dut3 (
    .clk(clk), .rst_n(rst3_n), .en(en3), .up_dn(up_dn3), .load(load3),
    .load_val(load_val3), .out_ready(out_ready3), .out_valid(out_valid3),
    .bin_q(bin_q3), .gray_q(gray_q3), .tc(tc3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Independent decoder: search for the binary value whose Gray code matches.
  function automatic int decode3(input logic [2:0] g);
    for (int b = 0; b < 8; b++) begin
      if (gray_of(b) == int'(g)) return b;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge for a counter of 2**w states.
  task automatic model_edge(input int w, input logic rn, input logic e, input logic u,
                            input logic ld, input int lv, input logic rdy,
                            inout int bin, inout int valid, inout int tcv);
    int modv;
    modv = 1 << w;
    if (!rn) begin
      bin = 0; valid = 0; tcv = 0;
    end else begin
      if (ld) begin
        bin = lv; tcv = 0;
      end else if (valid != 0 && rdy && e) begin
        if (u) begin
          tcv = (bin == modv - 1) ? 1 : 0;
          bin = (bin + 1) % modv;
        end else begin
          tcv = (bin == 0) ? 1 : 0;
          bin = (bin + modv - 1) % modv;
        end
      end else begin
        tcv = 0;
      end
      valid = 1;
    end
  endtask

  task automatic check4(input string tag);
    chk({tag, ".bin"},   32'(bin_q),     32'(m4_bin));
    chk({tag, ".gray"},  32'(gray_q),    32'(gray_of(m4_bin)));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m4_valid));
    chk({tag, ".tc"},    32'(tc),        32'(m4_tc));
    chk({tag, ".err"},   32'(err),       32'd0);
  endtask

  // Advance one edge on the W=4 instance, update the model, check outputs.
  task automatic tick4(input string tag);
    @(posedge clk);
    #1;
    model_edge(4, rst_n, en, up_dn, load, int'(load_val), out_ready, m4_bin, m4_valid, m4_tc);
    check4(tag);
  endtask

  task automatic tick3();
    @(posedge clk);
    #1;
    model_edge(3, rst3_n, en3, up_dn3, load3, int'(load_val3), out_ready3, m3_bin, m3_valid, m3_tc);
    chk("rt.bin",    32'(bin_q3),           32'(m3_bin));
    chk("rt.decode", 32'(decode3(gray_q3)), 32'(bin_q3));
    chk("rt.tc",     32'(tc3),              32'(m3_tc));
    chk("rt.err",    32'(err3),             32'd0);
  endtask

  initial begin
    int exp_gray [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int tc_count;

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0; out_ready = 1'b0;
    rst3_n = 1'b0; en3 = 1'b0; up_dn3 = 1'b1; load3 = 1'b0; load_val3 = 3'd0; out_ready3 = 1'b0;
    m4_bin = 0; m4_valid = 0; m4_tc = 0;
    m3_bin = 0; m3_valid = 0; m3_tc = 0;

    // Reset state before any clock edge
    #2;
    check4("reset");
    tick4("reset_hold");

    // 1: full up count, 17 edges after release
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1; out_ready = 1'b1;
    tc_count = 0;
    for (int i = 0; i < 17; i++) begin
      tick4("count_up");
      chk("seq_gray", 32'(gray_q), 32'(exp_gray[i]));
      chk("seq_tc", 32'(tc), (i == 16) ? 32'd1 : 32'd0);
      if (tc === 1'b1) tc_count++;
    end
    chk("tc_pulses", 32'(tc_count), 32'd1);

    // 2: down wrap from 0
    up_dn = 1'b0;
    tick4("down_wrap");
    chk("dn_bin", 32'(bin_q), 32'hF);
    chk("dn_gray", 32'(gray_q), 32'h8);
    chk("dn_tc", 32'(tc), 32'd1);
    tick4("down_next");
    chk("dn2_gray", 32'(gray_q), 32'h9);
    chk("dn2_tc", 32'(tc), 32'd0);

    // 3: backpressure at 5
    load = 1'b1; load_val = 4'd5;
    tick4("load5");
    load = 1'b0; out_ready = 1'b0; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick4("backpressure");
      chk("bp_gray", 32'(gray_q), 32'h7);
    end
    out_ready = 1'b1;
    tick4("bp_release");
    chk("bp_rel_bin", 32'(bin_q), 32'h6);
    chk("bp_rel_gray", 32'(gray_q), 32'h5);

    // 4: load beats a concurrent step
    load = 1'b1; load_val = 4'hA;
    tick4("loadA");
    chk("ldA_gray", 32'(gray_q), 32'hF);
    load = 1'b0;
    tick4("after_loadA");
    chk("ldA_next_gray", 32'(gray_q), 32'hE);

    // 5: asynchronous reset mid-count
    load = 1'b1; load_val = 4'd7;
    tick4("load7");
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m4_bin = 0; m4_valid = 0; m4_tc = 0;
    check4("async_rst");
    tick4("rst_low");
    rst_n = 1'b1;
    tick4("rst_release");
    chk("rel_valid", 32'(out_valid), 32'd1);
    chk("rel_bin", 32'(bin_q), 32'd0);
    // load in the cycle right after release
    #2; rst_n = 1'b0; #1;
    m4_bin = 0; m4_valid = 0; m4_tc = 0;
    tick4("rst_low2");
    rst_n = 1'b1; load = 1'b1; load_val = 4'd3;
    tick4("load_after_rel");
    chk("lrel_bin", 32'(bin_q), 32'd3);
    load = 1'b0;

    // Randomized traffic on W=4 against the model
    for (int i = 0; i < 300; i++) begin
      en        = 1'($urandom_range(0, 3) != 0);
      up_dn     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      load      = 1'($urandom_range(0, 9) == 0);
      load_val  = 4'($urandom_range(0, 15));
      tick4("rand4");
    end

    // 6: W=3 round trip through an independent decoder
    tick3();
    rst3_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      en3        = 1'($urandom_range(0, 3) != 0);
      up_dn3     = 1'($urandom_range(0, 1));
      out_ready3 = 1'($urandom_range(0, 3) != 0);
      load3      = 1'($urandom_range(0, 11) == 0);
      load_val3  = 3'($urandom_range(0, 7));
      tick3();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_gray_cnt.md
Name: bin_gray_cnt

Overview:
Registered binary-to-Gray up/down counter. It produces a W-bit binary count and its Gray-coded equivalent, and presents both over a valid/ready interface. It is the encoding end paired with the team's Gray-to-binary decoder. It sources Gray-coded pointers and sequences for clock-domain-crossing logic and position encoders.

Parameters:
W, 4, counter and code width in bits; legal range W >= 2.
INIT, 0, binary value loaded at reset; must be < 2**W.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  count enable; steps are taken only on a handshake cycle
up_dn  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load request
load_val  input  W  binary value used by load
out_ready  input  1  consumer ready
out_valid  output  1  current code is valid
bin_q  output  W  registered binary count
gray_q  output  W  registered Gray code; always equals bin_q ^ (bin_q >> 1)
tc  output  1  one-cycle pulse on wrap-around
err  output  1  sticky flag: a step changed more than one Gray bit

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n. When rst_n = 0, outputs take these values immediately, without waiting for a clock edge:
  - bin_q = INIT
  - gray_q = bin2gray(INIT)
  - out_valid = 0
  - tc = 0
  - err = 0
- out_valid rises on the first rising edge with rst_n = 1, then stays 1 until the next reset.
- Handshake: xfer = out_valid & out_ready. The code on bin_q/gray_q is consumed on an xfer cycle.
- Step: step = xfer & en & ~load. On the next edge:
  - bin_q <= bin_q ± 1, modulo 2**W.
  - gray_q <= bin2gray of the new bin_q, computed from the next-state value. gray_q therefore has zero extra latency relative to bin_q.
- Hold: with en = 0 or out_ready = 0 (and no load), all outputs hold. The code stays stable under backpressure.
- Load: load = 1 has priority over step and does not need xfer. On the next edge:
  - bin_q <= load_val
  - gray_q <= bin2gray(load_val)
  - tc <= 0
  - The err check is skipped for this update.
  - Load is legal in the cycle immediately after reset release. out_valid still rises on that edge.
- Wrap:
  - Up from 2**W-1 gives 0.
  - Down from 0 gives 2**W-1.
  - tc is registered: it is 1 for exactly the cycle following a wrapping step, else 0.
- Simultaneous up_dn change and step: the direction sampled in that cycle applies. A direction reversal is a legal 1-bit Gray change.
- err: on each step, compute popcount(old_gray ^ new_gray). If the result != 1, set err = 1. err clears only on reset; load does not clear it.
- Reset mid-operation (rst_n falls at any phase): outputs go to reset values immediately. A pending step or load is discarded.

Decomposition:
- Package gray_pkg holds:
  - function bin2gray(W)
  - function gray2bin(W)
  - function popcount
  - typedef dir_e {DN = 0, UP = 1}
- One sub-module, gray_step_chk: purely combinational; takes old_gray and new_gray and returns a one_bit_change flag. It feeds err and is reusable by the decoder-side bench.
- The counter registers, handshake and tc/err flops live in the top module.

Test Plan:
1. W=4, en=1, up_dn=1, out_ready=1, 17 cycles after reset → gray_q = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. tc pulses once, in the cycle gray_q returns to 0. err = 0.
2. W=4, up_dn=0, from 0, one step → bin_q = F, gray_q = 8, tc = 1 for one cycle. The next step gives bin_q = E, gray_q = 9.
3. Backpressure: count at bin_q = 5, en=1, out_ready=0 for 5 cycles → bin_q stays 5 and gray_q stays 7 throughout. out_ready=1 → bin_q = 6, gray_q = 5 one edge later.
4. Load 4'hA with en=1, out_ready=1 in the same cycle → bin_q = A, gray_q = F, no step, tc = 0, err = 0. The following up step gives gray_q = E.
5. Reset mid-count: at bin_q = 7, rst_n = 0 between edges → bin_q = INIT and out_valid = 0 before the next edge. First edge after release → out_valid = 1.
6. Round trip, W=3: gray_q drives the team's 3-bit Gray-to-binary decoder, with mixed random up/down/load/ready for 1000 cycles → decoded value == bin_q every cycle, and err never set.
